ppu_vram_port: RTL and testbench

- CPU-facing VRAM access port of the PPU: owns PPUADDR ($2006) and PPUDATA ($2007), with the t/v address registers, write toggle, read buffer and auto-increment.
- Drives the address, write-enable and write data into the VRAM mapper, and samples the mapper's read data.
- Muxes the renderer's fetch address onto the mapper address when rendering is active.
- Sits between the PPU register decoder and the VRAM mapper.

---
 rtl/ppu_vram_port.sv | 174 +++++++++++++++++
 tb/tb_ppu_vram_port.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_port.sv
`default_nettype none
// ============================================================================
// Module      : ppu_vram_port
// Description : PPUADDR/PPUDATA access port with t/v, toggle and read buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_vram_port #(
    parameter logic [13:0] PAL_BASE        = 14'h3F00,
    parameter logic [13:0] PAL_SHADOW_MASK = 14'h2FFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_reg,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        rd_valid,
    output logic        busy,
    input  logic        status_read,
    input  logic        inc32,
    input  logic        rendering_active,
    input  logic [13:0] render_addr,
    output logic [15:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_din,
    input  logic [7:0]  vram_dout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ADDR  = 3'd2,
        RD_CAP   = 3'd3,
        PAL_ADDR = 3'd4,
        PAL_CAP  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] t_q, t_d;
    logic [13:0] v_q, v_d;
    logic        w_q, w_d;
    logic [7:0]  buf_q, buf_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic [7:0]  vram_din_q, vram_din_d;
    logic        rd_valid_q, rd_valid_d;

    logic [13:0] v_inc;
    logic        acc_addr;
    logic        acc_data;
    logic [13:0] fsm_addr;

    // 14-bit sum wraps naturally at the top of the PPU address space
    assign v_inc    = v_q + (inc32 ? 14'd32 : 14'd1);
    assign acc_addr = cpu_cs & cpu_we & (cpu_reg == 3'd6) & (state_q == IDLE);
    assign acc_data = cpu_cs & (cpu_reg == 3'd7) & (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        v_d        = v_q;
        w_d        = w_q;
        buf_d      = buf_q;
        cpu_dout_d = cpu_dout_q;
        vram_din_d = vram_din_q;
        rd_valid_d = 1'b0;

        if (acc_addr) begin
            if (!w_q) begin
                t_d[13:8] = cpu_din[5:0];
                w_d       = 1'b1;
            end else begin
                t_d[7:0] = cpu_din;
                v_d      = {t_q[13:8], cpu_din};
                w_d      = 1'b0;
            end
        end
        // A $2002 read wins over a coincident toggle flip
        if (status_read) begin
            w_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (acc_data) begin
                    if (rendering_active) begin
                        v_d = v_inc;
                        if (!cpu_we) begin
                            cpu_dout_d = buf_q;
                            rd_valid_d = 1'b1;
                        end
                    end else if (cpu_we) begin
                        vram_din_d = cpu_din;
                        state_d    = WR;
                    end else begin
                        state_d = RD_ADDR;
                        if (v_q < PAL_BASE) begin
                            cpu_dout_d = buf_q;
                            rd_valid_d = 1'b1;
                        end
                    end
                end
            end
            WR: begin
                v_d     = v_inc;
                state_d = IDLE;
            end
            RD_ADDR: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                if (v_q >= PAL_BASE) begin
                    cpu_dout_d = vram_dout;
                    rd_valid_d = 1'b1;
                    state_d    = PAL_ADDR;
                end else begin
                    buf_d   = vram_dout;
                    v_d     = v_inc;
                    state_d = IDLE;
                end
            end
            PAL_ADDR: begin
                state_d = PAL_CAP;
            end
            PAL_CAP: begin
                buf_d   = vram_dout;
                v_d     = v_inc;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            t_q        <= 14'd0;
            v_q        <= 14'd0;
            w_q        <= 1'b0;
            buf_q      <= 8'd0;
            cpu_dout_q <= 8'd0;
            vram_din_q <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            v_q        <= v_d;
            w_q        <= w_d;
            buf_q      <= buf_d;
            cpu_dout_q <= cpu_dout_d;
            vram_din_q <= vram_din_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Palette reads refill the buffer from the nametable sitting underneath
    always_comb begin
        fsm_addr = v_q;
        if ((state_q == PAL_ADDR) || (state_q == PAL_CAP)) begin
            fsm_addr = v_q & PAL_SHADOW_MASK;
        end
    end

    assign vram_addr = rendering_active ? {2'b00, render_addr} : {2'b00, fsm_addr};
    assign vram_we   = (state_q == WR) & ~rendering_active;
    assign vram_din  = vram_din_q;
    assign cpu_dout  = cpu_dout_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppu_vram_port
// Description : Self-checking bench for ppu_vram_port with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_vram_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_cs, cpu_we;
    logic [2:0]  cpu_reg;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        rd_valid, busy;
    logic        status_read, inc32, rendering_active;
    logic [13:0] render_addr;
    logic [15:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_din;
    logic [7:0]  vram_dout;

    always #5 clk = ~clk;

    ppu_vram_port dut (
        .clk(clk), .reset_n(reset_n), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
        .cpu_reg(cpu_reg), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .rd_valid(rd_valid), .busy(busy), .status_read(status_read),
        .inc32(inc32), .rendering_active(rendering_active),
        .render_addr(render_addr), .vram_addr(vram_addr), .vram_we(vram_we),
        .vram_din(vram_din), .vram_dout(vram_dout)
    );

    // Mapper-side memory with one-cycle synchronous read
    logic [7:0]  mem [0:16383];
    logic        mem_clear, pl_we;
    logic [13:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
        end else begin
            if (pl_we) mem[pl_addr] <= pl_data;
            if (vram_we) mem[vram_addr[13:0]] <= vram_din;
        end
        vram_dout <= mem[vram_addr[13:0]];
    end

    // Reference model state
    logic [7:0]  ref_mem [0:16383];
    logic [13:0] mv;
    logic [7:0]  mbuf;
    int checks = 0;
    int errors = 0;

    function automatic logic [13:0] step(input logic [13:0] a);
        return 14'((int'(a) + (inc32 ? 32 : 1)) % 16384);
    endfunction

    task automatic cpu_access(input logic we, input logic [2:0] r, input logic [7:0] d, input logic st);
        @(negedge clk);
        cpu_cs = 1'b1; cpu_we = we; cpu_reg = r; cpu_din = d; status_read = st;
        @(negedge clk);
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_reg = 3'd0; cpu_din = 8'h00; status_read = 1'b0;
    endtask

    task automatic set_addr(input logic [13:0] a);
        cpu_access(1'b1, 3'd6, {2'b00, a[13:8]}, 1'b0);
        cpu_access(1'b1, 3'd6, a[7:0], 1'b0);
        mv = a;
    endtask

    task automatic preload(input logic [13:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic do_write(input logic [7:0] d, output int we_cnt, output logic [15:0] wa,
                            output logic [7:0] wd, output int bc);
        cpu_access(1'b1, 3'd7, d, 1'b0);
        we_cnt = 0; bc = 0; wa = 16'h0; wd = 8'h0;
        for (int i = 0; i < 6; i++) begin
            if (vram_we) begin we_cnt++; wa = vram_addr; wd = vram_din; end
            if (busy) bc++;
            @(negedge clk);
        end
        if (!rendering_active) ref_mem[mv] = d;
        mv = step(mv);
    endtask

    task automatic do_read(output logic [7:0] data, output int vcnt, output int bc, output logic [7:0] exp);
        if (rendering_active) begin
            exp = mbuf;
        end else if (mv >= 14'h3F00) begin
            exp  = ref_mem[mv];
            mbuf = ref_mem[mv & 14'h2FFF];
        end else begin
            exp  = mbuf;
            mbuf = ref_mem[mv];
        end
        mv = step(mv);
        cpu_access(1'b0, 3'd7, 8'h00, 1'b0);
        vcnt = 0; bc = 0; data = 8'h00;
        for (int i = 0; i < 6; i++) begin
            if (rd_valid) begin vcnt++; data = cpu_dout; end
            if (busy) bc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_reg = 3'd0; cpu_din = 8'h00;
        status_read = 1'b0; inc32 = 1'b0; rendering_active = 1'b0; render_addr = 14'h0;
        mem_clear = 1'b1; pl_we = 1'b0; pl_addr = 14'h0; pl_data = 8'h0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;
        mv = 14'h0; mbuf = 8'h00;
        repeat (2) @(negedge clk);
        mem_clear = 1'b0;
        checks++; if (vram_addr !== 16'h0000) begin errors++; $display("FAIL reset_vram_addr got %h want 0000", vram_addr); end
        checks++; if ({vram_we, busy, rd_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {vram_we, busy, rd_valid}); end
        checks++; if ({cpu_dout, vram_din} !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", {cpu_dout, vram_din}); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (vram_addr !== 16'h0000 || busy !== 1'b0) begin errors++; $display("FAIL post_reset got addr %h busy %b want 0000 0", vram_addr, busy); end
    endtask

    task automatic test_data_write();
        int wc, bc; logic [15:0] wa; logic [7:0] wd;
        cpu_access(1'b1, 3'd6, 8'h21, 1'b0);
        cpu_access(1'b1, 3'd6, 8'h08, 1'b0);
        mv = 14'h2108;
        checks++; if (vram_addr !== 16'h2108) begin errors++; $display("FAIL ppuaddr_set got %h want 2108", vram_addr); end
        for (int k = 0; k < 2; k++) begin
            do_write(8'hAB, wc, wa, wd, bc);
            checks++; if (wc !== 1 || wa !== 16'(16'h2108 + k) || wd !== 8'hAB || bc !== 1) begin
                errors++; $display("FAIL data_write%0d got cnt %0d addr %h data %h busy %0d want 1 %h ab 1", k, wc, wa, wd, bc, 16'(16'h2108 + k));
            end
        end
        checks++; if (vram_addr !== 16'h210A) begin errors++; $display("FAIL write_v_end got %h want 210a", vram_addr); end
    endtask

    task automatic test_read_buffered();
        logic [7:0] d, e; int vc, bc;
        preload(14'h2000, 8'h55);
        set_addr(14'h2000);
        do_read(d, vc, bc, e);
        checks++; if (d !== 8'h00 || vc !== 1 || bc !== 2) begin errors++; $display("FAIL read_first got %h valid %0d busy %0d want 00 1 2", d, vc, bc); end
        do_read(d, vc, bc, e);
        checks++; if (d !== 8'h55 || vc !== 1 || bc !== 2) begin errors++; $display("FAIL read_second got %h valid %0d busy %0d want 55 1 2", d, vc, bc); end
    endtask

    task automatic test_palette_read();
        logic [7:0] d, e; int vc, bc;
        preload(14'h3F00, 8'h0F);
        preload(14'h2F00, 8'h66);
        set_addr(14'h3F00);
        do_read(d, vc, bc, e);
        checks++; if (d !== 8'h0F || vc !== 1 || bc !== 4) begin errors++; $display("FAIL pal_read got %h valid %0d busy %0d want 0f 1 4", d, vc, bc); end
        checks++; if (vram_addr !== 16'h3F01) begin errors++; $display("FAIL pal_v_end got %h want 3f01", vram_addr); end
        set_addr(14'h2108);
        do_read(d, vc, bc, e);
        checks++; if (d !== 8'h66) begin errors++; $display("FAIL pal_buffer got %h want 66", d); end
    endtask

    task automatic test_increment_wrap();
        int wc, bc; logic [15:0] wa; logic [7:0] wd;
        inc32 = 1'b1;
        set_addr(14'h3FF0);
        do_write(8'h5A, wc, wa, wd, bc);
        checks++; if (wc !== 1 || wa !== 16'h3FF0) begin errors++; $display("FAIL inc32_write got cnt %0d addr %h want 1 3ff0", wc, wa); end
        checks++; if (vram_addr !== 16'h0010) begin errors++; $display("FAIL inc32_wrap got %h want 0010", vram_addr); end
        inc32 = 1'b0;
        set_addr(14'h3FFF);
        do_write(8'hC3, wc, wa, wd, bc);
        checks++; if (vram_addr !== 16'h0000) begin errors++; $display("FAIL inc1_wrap got %h want 0000", vram_addr); end
    endtask

    task automatic test_toggle_and_busy();
        logic [7:0] d, e; int vc, bc;
        cpu_access(1'b1, 3'd6, 8'h3F, 1'b0);
        cpu_access(1'b0, 3'd2, 8'h00, 1'b1);
        set_addr(14'h2000);
        checks++; if (vram_addr !== 16'h2000) begin errors++; $display("FAIL toggle_clear got %h want 2000", vram_addr); end
        cpu_access(1'b1, 3'd6, 8'h21, 1'b1);
        cpu_access(1'b1, 3'd6, 8'h23, 1'b0);
        cpu_access(1'b1, 3'd6, 8'h45, 1'b0);
        mv = 14'h2345;
        checks++; if (vram_addr !== 16'h2345) begin errors++; $display("FAIL toggle_coincident got %h want 2345", vram_addr); end
        preload(14'h2345, 8'h3C);
        mbuf = ref_mem[mv]; mv = step(mv);
        cpu_access(1'b0, 3'd7, 8'h00, 1'b0);
        cpu_access(1'b1, 3'd6, 8'h11, 1'b0);
        @(negedge clk);
        checks++; if (vram_addr !== 16'h2346 || busy !== 1'b0) begin errors++; $display("FAIL busy_ignore got %h busy %b want 2346 0", vram_addr, busy); end
        set_addr(14'h2108);
        checks++; if (vram_addr !== 16'h2108) begin errors++; $display("FAIL busy_toggle got %h want 2108", vram_addr); end
        do_read(d, vc, bc, e);
        checks++; if (d !== 8'h3C || d !== e) begin errors++; $display("FAIL busy_buffer got %h want 3c", d); end
    endtask

    task automatic test_rendering();
        int wc, bc, vc; logic [15:0] wa; logic [7:0] wd, d, e;
        rendering_active = 1'b1;
        render_addr = 14'h1ABC;
        set_addr(14'h2400);
        checks++; if (vram_addr !== 16'h1ABC) begin errors++; $display("FAIL render_mux got %h want 1abc", vram_addr); end
        do_write(8'h77, wc, wa, wd, bc);
        checks++; if (wc !== 0 || bc !== 0) begin errors++; $display("FAIL render_write got we %0d busy %0d want 0 0", wc, bc); end
        rendering_active = 1'b0;
        @(negedge clk);
        checks++; if (vram_addr !== 16'h2401) begin errors++; $display("FAIL render_v got %h want 2401", vram_addr); end
        checks++; if (mem[14'h2400] !== ref_mem[14'h2400]) begin errors++; $display("FAIL render_mem got %h want %h", mem[14'h2400], ref_mem[14'h2400]); end
        rendering_active = 1'b1;
        do_read(d, vc, bc, e);
        checks++; if (d !== e || vc !== 1 || bc !== 0) begin errors++; $display("FAIL render_read got %h valid %0d busy %0d want %h 1 0", d, vc, bc, e); end
        rendering_active = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        preload(14'h2222, 8'h99);
        set_addr(14'h2222);
        cpu_access(1'b1, 3'd7, 8'h44, 1'b0);
        checks++; if (vram_we !== 1'b1) begin errors++; $display("FAIL midreset_we_before got %b want 1", vram_we); end
        reset_n = 1'b0;
        #1;
        checks++; if ({vram_we, busy, rd_valid} !== 3'b000 || vram_addr !== 16'h0 || {cpu_dout, vram_din} !== 16'h0) begin
            errors++; $display("FAIL midreset_outputs got we %b busy %b rv %b addr %h dout %h din %h want all 0", vram_we, busy, rd_valid, vram_addr, cpu_dout, vram_din);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (mem[14'h2222] !== 8'h99) begin errors++; $display("FAIL midreset_mem got %h want 99", mem[14'h2222]); end
        mv = 14'h0; mbuf = 8'h00;
    endtask

    task automatic test_random();
        int wc, bc, vc, bad; logic [15:0] wa; logic [7:0] wd, d, e; logic [13:0] a0;
        for (int n = 0; n < 120; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 1) begin
                a0 = ($urandom_range(0, 2) == 0) ? (14'h3F00 | 14'($urandom_range(0, 255))) : 14'($urandom_range(0, 16383));
                set_addr(a0);
                checks++; if (vram_addr !== (rendering_active ? {2'b00, render_addr} : {2'b00, mv})) begin
                    errors++; $display("FAIL rnd_addr got %h want %h", vram_addr, rendering_active ? {2'b00, render_addr} : {2'b00, mv});
                end
            end else if (op <= 4) begin
                a0 = mv;
                d = 8'($urandom);
                do_write(d, wc, wa, wd, bc);
                checks++;
                if (rendering_active ? (wc !== 0 || bc !== 0) : (wc !== 1 || bc !== 1 || wa !== {2'b00, a0} || wd !== d)) begin
                    errors++; $display("FAIL rnd_write got cnt %0d addr %h data %h busy %0d want addr %h data %h", wc, wa, wd, bc, a0, d);
                end
            end else if (op <= 7) begin
                a0 = mv;
                do_read(d, vc, bc, e);
                checks++;
                if (d !== e || vc !== 1 || bc !== (rendering_active ? 0 : (a0 >= 14'h3F00 ? 4 : 2))) begin
                    errors++; $display("FAIL rnd_read at %h got %h valid %0d busy %0d want %h", a0, d, vc, bc, e);
                end
            end else if (op == 8) begin
                inc32 = 1'($urandom);
            end else begin
                rendering_active = ~rendering_active;
                render_addr = 14'($urandom);
            end
        end
        rendering_active = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 16384; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rnd_memory got %0d differing bytes want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_read_buffered();
        test_palette_read();
        test_increment_wrap();
        test_toggle_and_busy();
        test_rendering();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
